// File: rtl/stage_sequencer_if.sv
// Stage sequencer bundle: start request, per-stage done/run handshake and
// the sequencer status outputs.
//   start               start level from a debounced key
//   done[NUM_STAGES]    done[k] raised by stage k when it has finished
//   run[NUM_STAGES]     one-hot run strobes, run[k] = stage k owns the datapath
//   program_initialize  idle, waiting for the first start
//   busy                a stage sequence is in progress
//   finished            the last enabled stage has completed
//   error               a guarded stage exceeded its watchdog
//   cur_stage           active or most recently active stage index
//   error_stage         stage index that timed out (latched)
// The master modport is the sequencer; the slave modport is the stage side.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 12
);
  logic                  start;
  logic [NUM_STAGES-1:0] done;
  logic [NUM_STAGES-1:0] run;
  logic                  program_initialize;
  logic                  busy;
  logic                  finished;
  logic                  error;
  logic [3:0]            cur_stage;
  logic [3:0]            error_stage;

  modport master (
    input  start, done,
    output run, program_initialize, busy, finished, error, cur_stage, error_stage
  );

  modport slave (
    output start, done,
    input  run, program_initialize, busy, finished, error, cur_stage, error_stage
  );
endinterface

// File: rtl/stage_sequencer.sv
// Stage sequencer: walks the enabled processing stages in index order, giving
// each one exclusive ownership of the shared RAM/VGA/HEX resources through a
// one-hot run strobe and waiting for that stage's done before moving on.
// A dead cycle (run = 0) separates consecutive stages so that datapath
// defaults settle between owners. Non-interactive stages are guarded by a
// watchdog; a stage that holds run for WATCHDOG_CYCLES cycles without done
// sends the sequencer to ERROR.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    stage_sequencer_if master modport (start, done in; run and status out)
module stage_sequencer #(
  parameter int                    NUM_STAGES      = 12,
  parameter logic [NUM_STAGES-1:0] ENABLE_MASK     = 12'hFFF,
  parameter logic [NUM_STAGES-1:0] NO_TIMEOUT_MASK = 12'h012,
  parameter logic [23:0]           WATCHDOG_CYCLES = 24'd10_000_000
) (
  input logic               clk,
  input logic               reset,
  stage_sequencer_if.master bus
);

  localparam int             WD_W     = $clog2(int'(WATCHDOG_CYCLES) + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cur_stage_q, cur_stage_d;
  logic [3:0]       error_stage_q, error_stage_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             start_q;

  logic             start_edge;
  logic [4:0]       first_hit;
  logic [4:0]       next_hit;
  logic             cur_done;
  logic             guarded;
  logic             timeout;

  // Lowest enabled stage index >= lo. Result is {found, index}.
  // Scanning downwards lets the lowest match overwrite higher ones.
  function automatic logic [4:0] find_enabled(input int lo);
    logic [4:0] r;
    r = 5'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= lo && ENABLE_MASK[i]) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

  assign start_edge = bus.start & ~start_q;
  assign first_hit  = find_enabled(0);
  assign next_hit   = find_enabled(int'(cur_stage_q) + 1);

  // Only the active stage's done bit is observed; a done level left over from
  // the previous stage therefore cannot advance the new one.
  assign cur_done = bus.done[cur_stage_q];
  assign guarded  = ~NO_TIMEOUT_MASK[cur_stage_q];

  // wd_q counts completed run cycles; the limit is hit on the edge that
  // would complete the WATCHDOG_CYCLES-th cycle of run.
  assign timeout = (wd_q + WD_W'(1)) == WD_LIMIT;

  always_comb begin
    state_d       = state_q;
    cur_stage_d   = cur_stage_q;
    error_stage_d = error_stage_q;
    wd_d          = wd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          wd_d = '0;
          if (first_hit[4]) begin
            state_d     = S_RUN;
            cur_stage_d = first_hit[3:0];
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // done has priority over a coincident timeout
        if (cur_done) begin
          state_d = S_GAP;
        end else if (guarded && timeout) begin
          state_d       = S_ERROR;
          error_stage_d = cur_stage_q;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_GAP: begin
        wd_d = '0;
        if (next_hit[4]) begin
          state_d     = S_RUN;
          cur_stage_d = next_hit[3:0];
        end else begin
          state_d = S_DONE;
        end
      end
      S_ERROR: begin
        if (start_edge) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_stage_q   <= 4'd0;
      error_stage_q <= 4'd0;
      wd_q          <= '0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_stage_q   <= cur_stage_d;
      error_stage_q <= error_stage_d;
      wd_q          <= wd_d;
      start_q       <= bus.start;
    end
  end

  // Outputs decode the state register directly, so an asynchronous reset
  // drops run at once.
  assign bus.run                = (state_q == S_RUN) ? (NUM_STAGES'(1) << cur_stage_q) : '0;
  assign bus.program_initialize = (state_q == S_IDLE);
  assign bus.busy               = (state_q == S_RUN) || (state_q == S_GAP);
  assign bus.finished           = (state_q == S_DONE);
  assign bus.error              = (state_q == S_ERROR);
  assign bus.cur_stage          = cur_stage_q;
  assign bus.error_stage        = error_stage_q;

endmodule
